// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment vector type, hex glyph table and
// a decode helper reused by single-digit decoders and multi-digit scanners.
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}, indexed by hex value.
  localparam seg_t SEG_LUT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Unknown selects fall through to the default so a blank is shown, never X.
  function automatic seg_t hex2seg(input logic [3:0] sel);
    case (sel)
      4'h0:    return SEG_LUT[0];
      4'h1:    return SEG_LUT[1];
      4'h2:    return SEG_LUT[2];
      4'h3:    return SEG_LUT[3];
      4'h4:    return SEG_LUT[4];
      4'h5:    return SEG_LUT[5];
      4'h6:    return SEG_LUT[6];
      4'h7:    return SEG_LUT[7];
      4'h8:    return SEG_LUT[8];
      4'h9:    return SEG_LUT[9];
      4'hA:    return SEG_LUT[10];
      4'hB:    return SEG_LUT[11];
      4'hC:    return SEG_LUT[12];
      4'hD:    return SEG_LUT[13];
      4'hE:    return SEG_LUT[14];
      4'hF:    return SEG_LUT[15];
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Purely combinational hex-to-segment lookup, active-high polarity.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] sel,
  output seg_t       pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    pattern = hex2seg(sel);
  end

endmodule

// File: rtl/seg_7_1_decoder.sv
// Registered single-digit hex to 7-segment decoder with selectable pad polarity.
module seg_7_1_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  output logic [6:0] segment
);

  localparam bit INVERT = (ACTIVE_LOW != 0);

  seg_t w_pattern_p0;
  seg_t w_drive_p0;
  seg_t w_blank;
  seg_t r_seg_p1;

  seg7_hex_lut u_lut (
    .sel     (sel),
    .pattern (w_pattern_p0)
  );

  // Common-anode pads want the complement of every bit, including blank.
  assign w_drive_p0 = INVERT ? ~w_pattern_p0 : w_pattern_p0;
  assign w_blank    = INVERT ? ~SEG_BLANK    : SEG_BLANK;

  // p0 -> p1: single output register feeding the pads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_p1 <= w_blank;
    end else begin
      r_seg_p1 <= w_drive_p0;
    end
  end

  assign segment = r_seg_p1;

endmodule

// File: tb/tb_seg_7_1_decoder.sv
// Bench for seg_7_1_decoder: both polarities driven in lockstep against a glyph model.
module tb_seg_7_1_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] sel;
  logic [6:0] seg_ah;
  logic [6:0] seg_al;

  int n_tests = 0;
  int n_fail  = 0;

  // Lit segments per glyph, by segment letter.
  string GLYPH [16] = '{
    "abcdef", "bc",     "abdeg",  "abcdg",
    "bcfg",   "acdfg",  "acdefg", "abc",
    "abcdefg","abcdfg", "abcefg", "cdefg",
    "adef",   "bcdeg",  "adefg",  "aefg"
  };

  seg_7_1_decoder #(.ACTIVE_LOW(0)) u_dut_ah (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .segment (seg_ah)
  );

  seg_7_1_decoder #(.ACTIVE_LOW(1)) u_dut_al (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .segment (seg_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_bits(input int v);
    logic [6:0] p;
    string      s;
    p = '0;
    s = GLYPH[v];
    for (int i = 0; i < s.len(); i++) begin
      p[int'(s[i]) - 97] = 1'b1;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge and look at the outputs 1 ns later; inputs are held across the edge.
  task automatic tick_and_check(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_ah"}, seg_ah, rst ? 7'b0000000 : glyph_bits(int'(sel)));
    chk({tag, "_al"}, seg_al, rst ? 7'b1111111 : ~glyph_bits(int'(sel)));
  endtask

  initial begin
    rst = 1'b1;
    sel = 4'h8;
    #1;

    // Reset held for two edges with sel=8 must still blank
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ah", seg_ah, 7'b0000000);
      chk("rst_al", seg_al, 7'b1111111);
    end

    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ah", seg_ah, 7'b1111111);
    chk("rel_al", seg_al, 7'b0000000);

    for (int v = 0; v <= 8; v++) begin
      sel = 4'(v);
      tick_and_check($sformatf("sweep%0d", v));
    end
    sel = 4'h0;
    @(posedge clk);
    #1;
    chk("al_zero", seg_al, 7'b1000000);

    for (int v = 10; v <= 15; v++) begin
      sel = 4'(v);
      tick_and_check($sformatf("hex%0h", v));
    end
    sel = 4'hB;
    @(posedge clk);
    #1;
    chk("lit_b", seg_ah, 7'b1111100);

    // Mid-stream reset pulse on a steady digit
    sel = 4'h5;
    tick_and_check("mid_pre");
    chk("mid_pre_lit", seg_ah, 7'b1101101);
    rst = 1'b1;
    tick_and_check("mid_rst");
    rst = 1'b0;
    tick_and_check("mid_post");
    chk("mid_post_lit", seg_ah, 7'b1101101);

    for (int i = 0; i < 100; i++) begin
      sel = 4'($urandom % 16);
      tick_and_check($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
